// File: rtl/vesp_lsu_pkg.sv
// vesp_lsu_pkg
//   Shared definitions for the load/store unit: funct3 encodings, the LSU
//   FSM state type, the default WAIT timeout and a request legality check.
package vesp_lsu_pkg;

    localparam int unsigned LSU_TIMEOUT = 16;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // Returns 1 when the request must be answered with an error and never
    // reach memory: illegal funct3 (unsigned forms are load-only) or a
    // half/word access that is not naturally aligned.
    function automatic logic lsu_req_bad(input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                     (we && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/module_extend.sv
// module_extend
//   Widens an IN_W-bit value to OUT_W bits, sign- or zero-extending.
//   Ports:
//     din   in  IN_W   value to extend
//     uext  in  1      1 = zero extension, 0 = sign extension
//     dout  out OUT_W  extended value
module module_extend #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    input  logic             uext,
    output logic [OUT_W-1:0] dout
);

    always_comb begin
        dout = {{(OUT_W - IN_W){(~uext) & din[IN_W-1]}}, din};
    end

endmodule

// File: rtl/module_lsu.sv
// module_lsu
//   Single-outstanding load/store unit between a core request port and a
//   word-addressed memory port with request/grant and read-valid handshakes.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_valid/req_ready        core request handshake (ready only in IDLE)
//     req_we, req_funct3         store flag and access size/sign
//     req_addr, req_wdata        byte address, right-aligned store data
//     resp_valid                 one-cycle completion pulse
//     resp_rdata, resp_err       extended load data, error flag
//     mem_req/mem_gnt            memory request handshake
//     mem_we, mem_be             write flag, byte enables
//     mem_addr, mem_wdata        word address, lane-replicated store data
//     mem_rvalid, mem_rdata      read data return
module module_lsu
    import vesp_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    lsu_state_e      state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic            bad_req;
    logic            timeout_hit;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] byte_ext;
    logic [XLEN-1:0] half_ext;
    logic [XLEN-1:0] load_val;
    logic [3:0]      be_val;
    logic [XLEN-1:0] st_data;

    always_comb begin
        bad_req     = lsu_req_bad(req_we, req_funct3, req_addr[1:0]);
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end

    // State register plus every latched field.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= bad_req;
                rdata_q  <= '0;
            end
            if (state_q == ST_REQ && mem_gnt) begin
                cnt_q <= '0;
            end
            // rvalid wins over a timeout expiring in the same cycle.
            if (state_q == ST_WAIT) begin
                if (mem_rvalid) begin
                    rdata_q <= mem_rdata;
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = bad_req ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_gnt) state_d = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT: if (mem_rvalid || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane selection on the captured word, then extension.
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   byte_lane = rdata_q[7:0];
            2'b01:   byte_lane = rdata_q[15:8];
            2'b10:   byte_lane = rdata_q[23:16];
            default: byte_lane = rdata_q[31:24];
        endcase
        half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    module_extend #(.IN_W(8), .OUT_W(XLEN)) u_ext_b (
        .din  (byte_lane),
        .uext (funct3_q[2]),
        .dout (byte_ext)
    );

    module_extend #(.IN_W(16), .OUT_W(XLEN)) u_ext_h (
        .din  (half_lane),
        .uext (funct3_q[2]),
        .dout (half_ext)
    );

    always_comb begin
        unique case (funct3_q[1:0])
            2'b00: begin
                load_val = byte_ext;
                be_val   = 4'b0001 << addr_q[1:0];
                st_data  = {(XLEN / 8){wdata_q[7:0]}};
            end
            2'b01: begin
                load_val = half_ext;
                be_val   = 4'b0011 << addr_q[1:0];
                st_data  = {(XLEN / 16){wdata_q[15:0]}};
            end
            default: begin
                load_val = rdata_q;
                be_val   = 4'b1111;
                st_data  = wdata_q;
            end
        endcase
    end

    // Outputs decode from state; reset forces the quiescent values even while
    // state_q still holds a pre-reset state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset) begin
            req_ready = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: req_ready = 1'b1;
                ST_REQ: begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_be    = be_val;
                    mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                    mem_wdata = we_q ? st_data : '0;
                end
                ST_WAIT: begin
                end
                default: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                    if (!err_q && !we_q) resp_rdata = load_val;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_lsu.sv
module tb_module_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    module_lsu #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        give_rvalid;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                                input logic rv, input logic err, input logic [31:0] erd,
                                input logic [31:0] maddr, input logic [3:0] be,
                                input logic [31:0] ewd, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_dly = dly; v.give_rvalid = rv; v.exp_err = err; v.exp_rdata = erd;
        v.exp_maddr = maddr; v.exp_be = be; v.exp_wdata = ewd; v.exp_lat = lat;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          lat, reqc, gnt_k;
        logic        got, stable, rerr;
        logic [31:0] rdat, a0, a_g, wd_g;
        logic [3:0]  be_g;
        logic        we_g;
        lat = 0; reqc = 0; gnt_k = -1; got = 1'b0; stable = 1'b1; rerr = 1'b0;
        rdat = '0; a0 = '0; a_g = '0; wd_g = '0; be_g = '0; we_g = 1'b0;

        @(negedge clk);
        chk($sformatf("v%0d_ready_before", idx), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: the LSU must work from its latched copy.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        req_funct3 = 3'b111; req_we = ~v.we;
        for (int k = 1; k <= 60 && !got; k++) begin
            if (k > 1) @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
            if (resp_valid) begin
                got = 1'b1; lat = k; rerr = resp_err; rdat = resp_rdata;
            end else begin
                if (mem_req) begin
                    if (reqc == 0) a0 = mem_addr;
                    else if (mem_addr !== a0) stable = 1'b0;
                    reqc++;
                    if (reqc > v.gnt_dly) begin
                        mem_gnt = 1'b1; gnt_k = k;
                        a_g = mem_addr; be_g = mem_be; wd_g = mem_wdata; we_g = mem_we;
                    end
                end
                if (gnt_k > 0 && k == gnt_k + 1 && !v.we && v.give_rvalid) begin
                    mem_rvalid = 1'b1; mem_rdata = v.rdata;
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_err", idx), {31'b0, rerr}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_rdata", idx), rdat, v.exp_rdata);
        chk($sformatf("v%0d_req_cycles", idx), reqc, (v.exp_lat > 1) ? v.gnt_dly + 1 : 0);
        if (v.exp_lat > 1) begin
            chk($sformatf("v%0d_mem_addr", idx), a_g, v.exp_maddr);
            chk($sformatf("v%0d_mem_we", idx), {31'b0, we_g}, {31'b0, v.we});
            chk($sformatf("v%0d_addr_stable", idx), {31'b0, stable}, 32'd1);
            if (v.we) begin
                chk($sformatf("v%0d_mem_be", idx), {28'b0, be_g}, {28'b0, v.exp_be});
                chk($sformatf("v%0d_mem_wdata", idx), wd_g, v.exp_wdata);
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d_resp_one_cycle", idx), {31'b0, resp_valid}, 32'd0);
        chk($sformatf("v%0d_ready_after", idx), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Loads (we=0), stores (we=1), errors; latency counted from acceptance.
        vecs.push_back(mk(0, 3'b000, 32'h103, 0, 32'h8F00_0000, 0, 1, 0, 32'hFFFF_FF8F, 32'h100, 0, 0, 3));
        vecs.push_back(mk(0, 3'b100, 32'h103, 0, 32'h8F00_0000, 0, 1, 0, 32'h0000_008F, 32'h100, 0, 0, 3));
        vecs.push_back(mk(0, 3'b101, 32'h102, 0, 32'h8001_0000, 0, 1, 0, 32'h0000_8001, 32'h100, 0, 0, 3));
        vecs.push_back(mk(0, 3'b001, 32'h102, 0, 32'h8001_0000, 0, 1, 0, 32'hFFFF_8001, 32'h100, 0, 0, 3));
        vecs.push_back(mk(0, 3'b010, 32'h104, 0, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 32'h104, 0, 0, 3));
        vecs.push_back(mk(0, 3'b000, 32'h101, 0, 32'h0000_7F00, 0, 1, 0, 32'h0000_007F, 32'h100, 0, 0, 3));
        vecs.push_back(mk(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 0, 0, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 2));
        vecs.push_back(mk(1, 3'b001, 32'h200, 32'h1234_ABCD, 0, 0, 0, 0, 0, 32'h200, 4'b0011, 32'hABCD_ABCD, 2));
        vecs.push_back(mk(1, 3'b000, 32'h301, 32'hFFFF_FFA5, 0, 0, 0, 0, 0, 32'h300, 4'b0010, 32'hA5A5_A5A5, 2));
        vecs.push_back(mk(1, 3'b000, 32'h303, 32'h0000_0011, 0, 0, 0, 0, 0, 32'h300, 4'b1000, 32'h1111_1111, 2));
        vecs.push_back(mk(1, 3'b010, 32'h40C, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'h40C, 4'b1111, 32'hCAFE_F00D, 2));
        vecs.push_back(mk(0, 3'b010, 32'h001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b001, 32'h003, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b101, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b011, 32'h000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b100, 32'h000, 32'h77, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b010, 32'h002, 32'h77, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Grant held off 5 cycles, then no rvalid: 6 REQ cycles + 16 WAIT + DONE.
        vecs.push_back(mk(0, 3'b010, 32'h500, 0, 0, 5, 0, 1, 0, 32'h500, 0, 0, 23));
        vecs.push_back(mk(0, 3'b000, 32'h010, 0, 32'h0000_00FF, 2, 1, 0, 32'hFFFF_FFFF, 32'h010, 0, 0, 5));
        vecs.push_back(mk(1, 3'b010, 32'h600, 32'h0BAD_F00D, 0, 3, 0, 0, 0, 32'h600, 4'b1111, 32'h0BAD_F00D, 5));

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Stray rvalid in IDLE must not produce a response.
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("stray_rvalid_ready", {31'b0, req_ready}, 32'd1);

        // Reset while in WAIT aborts the access; later rvalid is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_mem_req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("abort_in_wait_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_during_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_during_rst_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready_after_rst", {31'b0, req_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_BABE;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                mem_rvalid = 1'b0;
                if (resp_valid || mem_req) seen = 1'b1;
            end
            chk("abort_no_resp", {31'b0, seen}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/module_lsu.md
MODULE_LSU -- requirements
Module: module_lsu

Interface
REQ-001 Parameter: XLEN, 32, data/address width.
REQ-002 Parameter: TIMEOUT, 16, maximum WAIT cycles before error.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result.
- resp_err  out  1  misaligned, illegal or timeout; valid with resp_valid.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted request.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables.
- mem_addr  out  XLEN  word address, bits [1:0] = 00.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data word.

Function
REQ-004 FSM states IDLE, REQ, WAIT, DONE; req_ready = 1 only in IDLE.
REQ-005 Accept on req_valid && req_ready; latch we, funct3, addr, wdata.
REQ-006 Misalignment is addr[0]=1 for h/hu, or addr[1:0]≠00 for w. Illegal funct3 is 011, 110, 111 (any funct3 with bit 2 set for a store).
REQ-007 A misaligned or illegal request goes IDLE->DONE with no mem_req. The response is resp_err=1, resp_rdata=0.
REQ-008 A legal request goes IDLE->REQ. mem_req stays high with stable mem_* outputs until mem_gnt.
REQ-009 In REQ on mem_gnt: a store goes to DONE and a load goes to WAIT.
REQ-010 In WAIT on mem_rvalid: capture mem_rdata and go to DONE.
REQ-011 A WAIT counter resets on entry. If TIMEOUT cycles pass without mem_rvalid, go to DONE with resp_err=1, resp_rdata=0.
REQ-012 DONE lasts one cycle with resp_valid=1, then returns to IDLE.
REQ-013 Byte enables and store data:
- sb: mem_be = 0001<<addr[1:0], mem_wdata = byte replicated x4.
- sh: mem_be = 0011<<addr[1:0], mem_wdata = half replicated x2.
- sw: mem_be = 1111, mem_wdata = wdata.
REQ-014 Load lane selection: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
REQ-015 Load extension: sign extension when funct3[2]=0, zero extension when funct3[2]=1. A word load passes through.
REQ-016 A store response has resp_rdata = 0.
REQ-017 Zero-wait memory timing, with acceptance at cycle t:
- mem_req at t+1 with same-cycle gnt.
- rvalid at t+2.
- resp_valid at t+3 for a load, t+2 for a store.
REQ-018 A mem_rvalid outside WAIT is ignored. req_valid outside IDLE is ignored (no queueing).

Reset
REQ-019 When reset is sampled high: state = IDLE, counter = 0, all latched fields = 0.
REQ-020 Output values during reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0.
REQ-021 A reset in REQ/WAIT/DONE aborts the access with no resp_valid. A later stale mem_rvalid is ignored.

Structure
REQ-022 Funct3 encodings, the FSM state enum and the TIMEOUT default belong in a shared package, vesp_lsu_pkg.
REQ-023 Extension uses the existing sub-module module_extend, instantiated as #(8,32) and #(16,32), with uext = funct3[2].
REQ-024 All state is in one always_ff on clk. Outputs decode from registered state.

Verification
REQ-025 lb at addr 0x103 with mem_rdata 0x8F00_0000 -> resp_rdata 0xFFFF_FF8F, mem_addr 0x100, resp_valid at t+3.
REQ-026 lbu at the same addr and data -> resp_rdata 0x0000_008F. lhu at 0x102 with rdata 0x8001_0000 -> 0x0000_8001.
REQ-027 sh at addr 0x202 with wdata 0x1234_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we=1, resp_valid at t+2, resp_rdata 0.
REQ-028 lw at addr 0x001 -> no mem_req, resp_valid with resp_err=1 at t+1.
REQ-029 lw with mem_gnt held low 5 cycles -> mem_req and mem_addr stable for all 5 cycles. No rvalid for 16 cycles -> resp_err=1.
REQ-030 reset pulsed in WAIT, then mem_rvalid -> no resp_valid, req_ready=1 the cycle after reset.
